// File: rtl/order_frame_tx_if.sv
// Command and receiver-side signals of the order frame transmitter.
// rec_en qualifies buf_out for exactly one cycle; order_full high forbids starting a new frame.
interface order_frame_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          cmd_inc;
    logic          cmd_dec;
    logic          cmd_on;
    logic          cmd_off;
    logic          cmd_set;
    logic [7:0]    cmd_amount;
    logic          order_full;
    logic [24:0]   buf_out;
    logic          rec_en;
    logic          cmd_drop;
    logic [LW-1:0] fifo_level;
    logic          busy;

    modport master (
        input  cmd_inc, cmd_dec, cmd_on, cmd_off, cmd_set, cmd_amount, order_full,
        output buf_out, rec_en, cmd_drop, fifo_level, busy
    );

    modport slave (
        output cmd_inc, cmd_dec, cmd_on, cmd_off, cmd_set, cmd_amount, order_full,
        input  buf_out, rec_en, cmd_drop, fifo_level, busy
    );
endinterface

// File: rtl/order_frame_tx.sv
// Encodes operator commands into 25-bit order frames, buffers them and
// strobes them out one at a time with backpressure and a minimum idle gap.
module order_frame_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    order_frame_tx_if.master  bus,
    output logic [1:0]        dbg_state_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    localparam logic [2:0] OP_INC = 3'b001;
    localparam logic [2:0] OP_DEC = 3'b010;
    localparam logic [2:0] OP_ON  = 3'b011;
    localparam logic [2:0] OP_OFF = 3'b100;
    localparam logic [2:0] OP_SET = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    gap_q, gap_d;
    logic [7:0]    seq_q;
    logic [24:0]   buf_q;
    logic          drop_q;
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] count_q, count_d;
    logic [10:0]   mem_q [FIFO_DEPTH];

    logic          win_valid;
    logic [2:0]    win_op;
    logic [7:0]    win_amt;
    logic [2:0]    n_req;
    logic          push, pop, load_buf, drop_d;
    logic [10:0]   head;
    logic [23:0]   frame_body;

    // Command arbitration: off > on > set > dec > inc.
    always_comb begin
        win_valid = 1'b1;
        win_op    = OP_INC;
        win_amt   = 8'd0;
        n_req     = 3'({2'b00, bus.cmd_inc}) + 3'({2'b00, bus.cmd_dec}) +
                    3'({2'b00, bus.cmd_on}) + 3'({2'b00, bus.cmd_off}) +
                    3'({2'b00, bus.cmd_set});
        if (bus.cmd_off) begin
            win_op = OP_OFF;
        end else if (bus.cmd_on) begin
            win_op = OP_ON;
        end else if (bus.cmd_set) begin
            win_op  = OP_SET;
            win_amt = bus.cmd_amount;
        end else if (bus.cmd_dec) begin
            win_op  = OP_DEC;
            win_amt = bus.cmd_amount;
        end else if (bus.cmd_inc) begin
            win_op  = OP_INC;
            win_amt = bus.cmd_amount;
        end else begin
            win_valid = 1'b0;
        end
    end

    // The head pops at the end of the send cycle, so a full FIFO still accepts then.
    assign pop    = (state_q == S_SEND);
    assign push   = win_valid && ((count_q != FULL_LEVEL) || pop);
    assign drop_d = (n_req > 3'd1) || (win_valid && !push);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= {win_op, win_amt};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        load_buf = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && !bus.order_full) begin
                    state_d  = S_SEND;
                    load_buf = 1'b1;
                end
            end
            S_SEND: begin
                if (GAP_CYCLES > 0) begin
                    state_d = S_GAP;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequence number and parity are attached only when the frame leaves the FIFO.
    assign head       = mem_q[rd_q];
    assign frame_body = {1'b1, head[10:8], head[7:0], seq_q, 4'b0000};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gap_q   <= 4'd0;
            seq_q   <= 8'd0;
            buf_q   <= 25'd0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            if (load_buf) begin
                buf_q <= {frame_body, ^frame_body};
            end
            if (pop) begin
                seq_q <= seq_q + 8'd1;
            end
        end
    end

    assign bus.buf_out    = buf_q;
    assign bus.rec_en     = (state_q == S_SEND);
    assign bus.cmd_drop   = drop_q;
    assign bus.fifo_level = count_q;
    assign bus.busy       = (state_q != S_IDLE) || (count_q != '0);
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_order_frame_tx.sv
// Randomised and directed bench for order_frame_tx against a queue-based frame model.
module tb_order_frame_tx;
  localparam int DEPTH = 4;
  localparam int GAP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbg_state;

  order_frame_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  order_frame_tx #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int strobe_count = 0;
  int drop_count = 0;
  int last_strobe_cyc = -1;
  logic [24:0] last_strobe_buf = '0;

  // reference model: queue of {opcode, amount}, sequence number, earliest idle cycle
  logic [10:0] exp_q[$];
  logic [7:0] m_seq = 8'd0;
  int idle_from = 0;
  logic e_rec = 1'b0;
  logic e_drop = 1'b0;
  logic e_busy = 1'b0;
  int e_level = 0;
  logic [24:0] e_buf = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", tag, obs, exp, cyc);
  endtask

  function automatic logic [24:0] encode(input logic [10:0] item, input logic [7:0] seq);
    logic [23:0] body;
    body = {1'b1, item[10:8], item[7:0], seq, 4'b0000};
    return {body, ^body};
  endfunction

  task automatic model_step(input logic [4:0] cmds, input logic [7:0] amt, input logic full, input logic r);
    logic pop, decide, have, accept;
    logic [2:0] op;
    logic [7:0] a;
    if (r) begin
      exp_q.delete();
      m_seq = 8'd0;
      idle_from = cyc + 1;
      e_rec = 1'b0;
      e_drop = 1'b0;
      e_level = 0;
      e_buf = '0;
      e_busy = 1'b0;
      return;
    end
    pop = e_rec;
    decide = !pop && (cyc >= idle_from) && (exp_q.size() > 0) && !full;
    have = 1'b1;
    a = amt;
    if (cmds[4]) begin op = 3'b100; a = 8'd0; end
    else if (cmds[3]) begin op = 3'b011; a = 8'd0; end
    else if (cmds[2]) op = 3'b101;
    else if (cmds[1]) op = 3'b010;
    else if (cmds[0]) op = 3'b001;
    else begin op = 3'b000; have = 1'b0; end
    accept = have && ((exp_q.size() < DEPTH) || pop);
    e_drop = ($countones(cmds) > 1) || (have && !accept);
    if (decide) e_buf = encode(exp_q[0], m_seq);
    if (pop) begin
      void'(exp_q.pop_front());
      m_seq = m_seq + 8'd1;
      idle_from = cyc + GAP + 1;
    end
    if (accept) exp_q.push_back({op, a});
    e_rec = decide;
    e_level = exp_q.size();
    e_busy = (exp_q.size() != 0) || decide || (cyc + 1 < idle_from);
  endtask

  // driver: check this cycle's outputs, apply inputs, advance the model
  // cmds = {off, on, set, dec, inc}
  task automatic cycle(input logic [4:0] cmds, input logic [7:0] amt, input logic full, input logic r);
    @(negedge clk);
    check_eq("rec_en", 32'(bus.rec_en), 32'(e_rec));
    check_eq("cmd_drop", 32'(bus.cmd_drop), 32'(e_drop));
    check_eq("fifo_level", 32'(bus.fifo_level), e_level);
    check_eq("busy", 32'(bus.busy), 32'(e_busy));
    check_eq("buf_out", 32'(bus.buf_out), 32'(e_buf));
    if (bus.rec_en) begin
      check_eq("parity", 32'(^bus.buf_out), 32'd0);
      strobe_count++;
      last_strobe_cyc = cyc;
      last_strobe_buf = bus.buf_out;
    end
    if (bus.cmd_drop) drop_count++;
    rst = r;
    bus.cmd_inc = cmds[0];
    bus.cmd_dec = cmds[1];
    bus.cmd_set = cmds[2];
    bus.cmd_on = cmds[3];
    bus.cmd_off = cmds[4];
    bus.cmd_amount = amt;
    bus.order_full = full;
    model_step(cmds, amt, full, r);
    cyc++;
  endtask

  task automatic idle(input int n, input logic full);
    for (int i = 0; i < n; i++) cycle(5'b00000, 8'($urandom_range(0, 255)), full, 1'b0);
  endtask

  initial begin
    int req_c, s0, d0;
    bus.cmd_inc = 1'b0;
    bus.cmd_dec = 1'b0;
    bus.cmd_on = 1'b0;
    bus.cmd_off = 1'b0;
    bus.cmd_set = 1'b0;
    bus.cmd_amount = 8'd0;
    bus.order_full = 1'b0;

    for (int i = 0; i < 3; i++) cycle(5'b00000, 8'd0, 1'b0, 1'b1);

    // single set command
    last_strobe_cyc = -1;
    req_c = cyc;
    cycle(5'b00100, 8'h5A, 1'b0, 1'b0);
    idle(8, 1'b0);
    check_eq("single_latency", 32'(last_strobe_cyc - req_c), 32'd2);
    check_eq("single_frame", 32'(last_strobe_buf), 32'h01AB4001);

    // priority: off wins over inc and set
    d0 = drop_count;
    cycle(5'b10101, 8'h33, 1'b0, 1'b0);
    idle(10, 1'b0);
    check_eq("prio_op_amt", 32'(last_strobe_buf[23:13]), 32'({3'b100, 8'h00}));
    check_eq("prio_drops", 32'(drop_count - d0), 32'd1);

    // backpressure and overflow
    s0 = strobe_count;
    d0 = drop_count;
    for (int i = 0; i < 5; i++) cycle(5'b00001, 8'(i + 1), 1'b1, 1'b0);
    idle(3, 1'b1);
    check_eq("bp_no_strobe", 32'(strobe_count - s0), 32'd0);
    check_eq("bp_level", 32'(bus.fifo_level), 32'd4);
    check_eq("bp_drop", 32'(drop_count - d0), 32'd1);
    idle(25, 1'b0);
    check_eq("bp_strobes", 32'(strobe_count - s0), 32'd4);

    // sequence wrap, paced so the FIFO never overflows
    d0 = drop_count;
    s0 = strobe_count;
    for (int i = 0; i < 257; i++) begin
      cycle(5'b00001, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      idle(GAP + 1, 1'b0);
    end
    idle(10, 1'b0);
    check_eq("wrap_no_drop", 32'(drop_count - d0), 32'd0);
    check_eq("wrap_strobes", 32'(strobe_count - s0), 32'd257);

    // reset during the gap with two frames still queued
    cycle(5'b00001, 8'h11, 1'b0, 1'b0);
    cycle(5'b00001, 8'h22, 1'b0, 1'b0);
    cycle(5'b00001, 8'h33, 1'b0, 1'b0);
    cycle(5'b00000, 8'h00, 1'b0, 1'b0);
    check_eq("mid_gap_level", 32'(bus.fifo_level), 32'd2);
    cycle(5'b00000, 8'h00, 1'b0, 1'b1);
    idle(2, 1'b0);
    cycle(5'b00010, 8'h44, 1'b0, 1'b0);
    idle(8, 1'b0);
    check_eq("post_reset_seq", 32'(last_strobe_buf[12:5]), 32'd0);

    // push into a full FIFO in the cycle its head is sent
    d0 = drop_count;
    for (int i = 0; i < 4; i++) cycle(5'b00001, 8'(i + 8), 1'b1, 1'b0);
    idle(2, 1'b1);
    cycle(5'b00000, 8'h00, 1'b0, 1'b0);
    cycle(5'b00010, 8'h77, 1'b0, 1'b0);
    cycle(5'b00000, 8'h00, 1'b0, 1'b0);
    check_eq("full_pushpop_level", 32'(bus.fifo_level), 32'd4);
    check_eq("full_pushpop_drop", 32'(drop_count - d0), 32'd0);
    idle(30, 1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] c;
      for (int b = 0; b < 5; b++) c[b] = ($urandom_range(0, 7) == 0);
      cycle(c, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 499) == 0));
    end
    idle(30, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/order_frame_tx.md
Name: order_frame_tx

Overview:
- Transmit-side counterpart of the order receive unit.
- Captures operator commands (increase, decrease, on, off, set-amount) and encodes each into a 25-bit order frame.
- Buffers frames in a small FIFO and presents them one at a time on the 25-bit buffer bus with a one-cycle receive-enable strobe.
- Honours the receiver's order-full backpressure and enforces a minimum idle gap between frames.

Parameters:
- FIFO_DEPTH, 4, number of buffered frames; power of two, 2..16.
- GAP_CYCLES, 3, minimum rec_en-low cycles after each strobe; 0..15.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_inc  in  1  increase request, sampled each cycle.
- cmd_dec  in  1  decrease request.
- cmd_on  in  1  output-on request.
- cmd_off  in  1  output-off request.
- cmd_set  in  1  set-amount request.
- cmd_amount  in  8  amount/step for inc, dec and set.
- order_full  in  1  receiver busy; no strobe may be issued while high.
- buf_out  out  25  frame to receiver.
- rec_en  out  1  one-cycle strobe, buf_out valid.
- cmd_drop  out  1  one-cycle pulse, a request was lost.
- fifo_level  out  log2(FIFO_DEPTH)+1  frames currently buffered.
- busy  out  1  high when not in IDLE or FIFO non-empty.

Behaviour:
- Reset: all outputs 0, FIFO empty, sequence counter 0, FSM in IDLE. Reset mid-operation discards buffered frames and any in-flight strobe; rec_en is low in the cycle after the reset edge.
- Frame format:
  - [24] marker = 1.
  - [23:21] opcode: inc=001, dec=010, on=011, off=100, set=101.
  - [20:13] amount: cmd_amount for inc/dec/set, 0 for on/off.
  - [12:5] sequence number.
  - [4:1] = 0.
  - [0] even parity over [24:1]; XOR of [24:0] = 0.
- Command capture (every cycle):
  - Several requests high in one cycle: priority off > on > set > dec > inc. Only the winner is encoded; each loser sets cmd_drop for one cycle.
  - FIFO full: the winner is also dropped (cmd_drop = 1) and nothing changes.
  - Requests are level-sampled; a request held for N cycles enqueues N frames.
  - The FIFO stores opcode and amount only. Sequence and parity are added at send time.
- Sequence counter: 8 bits, increments once per issued strobe, wraps 255 -> 0. Dropped commands do not consume a number.
- FSM:
  - IDLE -> SEND when FIFO non-empty and order_full = 0. Otherwise stay.
  - SEND (1 cycle): rec_en = 1, buf_out = encoded head frame, FIFO pops, sequence increments. Next state is GAP if GAP_CYCLES > 0, else IDLE.
  - GAP: count GAP_CYCLES cycles with rec_en = 0, then IDLE. order_full is ignored here.
- Timing:
  - Latency: request in cycle 0, into empty FIFO, FSM IDLE, order_full low -> rec_en high in cycle 2.
  - Back-to-back minimum strobe spacing is GAP_CYCLES + 2 cycles.
  - order_full is sampled only in IDLE. Asserting it in the same cycle as the SEND decision blocks the send.
- buf_out holds its last value when rec_en = 0; only rec_en qualifies it.
- Push and pop in the same cycle: both are honoured, and fifo_level is unchanged. This includes a push into a full FIFO in the cycle the head pops (accepted, no drop).
- fifo_level is registered and reflects the state after the current edge.

Test Plan:
- Single command: after reset, cmd_set = 1 with cmd_amount = 0x5A for one cycle -> rec_en pulse in cycle 2, buf_out = {1, 101, 0x5A, 0x00, 0000, p}; parity holds; fifo_level returns to 0.
- Priority: cmd_off, cmd_inc and cmd_set high together for one cycle -> one frame with opcode 100 and amount 0; cmd_drop high for one cycle.
- Backpressure and overflow: order_full held high, five single-cycle cmd_inc requests (FIFO_DEPTH = 4) -> fifo_level reaches 4, the fifth request pulses cmd_drop, no rec_en. Release order_full -> four strobes with sequence 0..3, spaced 5 cycles apart (GAP_CYCLES = 3).
- Sequence wrap: issue 257 frames -> the frame after sequence 255 carries sequence 0; no cmd_drop.
- Reset mid-gap: reset asserted during GAP with 2 frames queued -> rec_en = 0 and fifo_level = 0 from the next cycle; next command uses sequence 0.
- Simultaneous push/pop at full: FIFO full and SEND cycle coincides with cmd_dec -> frame accepted, fifo_level stays 4, cmd_drop = 0.
